// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the instruction fetch slice.
//   - XLEN / INST_W      : address and instruction widths
//   - RESET_PC_DEFAULT   : default address of the first fetch after reset
//   - OPC_*              : base-ISA major opcodes (if_inst[6:0]) used by decode
//   - fetch_state_e      : fetch FSM encoding
//   - align_pc()         : clears the two low address bits
package fetch_unit_pkg;

    localparam int          XLEN             = 32;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry registered buffer between instruction memory and decode.
//   clk, rst_n           : clock, asynchronous active-low reset
//   push, push_data      : write one entry (ignored when full)
//   pop                  : remove the head entry (ignored when empty)
//   flush                : empty the buffer; overrides push and pop in the same cycle
//   head_data            : oldest entry (zero after reset)
//   count, empty, full   : occupancy status
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head_data,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign empty     = (count_q == 2'd0);
    assign full      = (count_q == 2'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop) begin
                count_d = count_q + 2'd1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with one outstanding memory request,
// a two-entry instruction buffer and redirect (branch/jump) support.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   imem_req, imem_addr, imem_gnt       : request channel (accepted when req & gnt)
//   imem_rvalid, imem_rdata             : in-order read response
//   redirect, redirect_pc               : new fetch target from decode/execute
//   if_valid, if_inst, if_pc, if_ready  : instruction stream to decode
//   dbg_state                           : current fetch FSM state
//
// Handshakes: a memory request is accepted in a cycle where imem_req=1 and
// imem_gnt=1; an instruction is transferred to decode in a cycle where
// if_valid=1 and if_ready=1. if_inst/if_pc hold stable while if_valid=1 and
// if_ready=0 unless a redirect flushes the buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [XLEN-1:0]   if_pc,
    input  logic              if_ready,
    output fetch_state_e      dbg_state
);

    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    req_pc_q, req_pc_d;
    logic               grant;
    logic               fifo_push, fifo_pop;
    logic [1:0]         fifo_count;
    logic               fifo_empty, fifo_full;
    logic [XLEN+INST_W-1:0] fifo_head;
    logic [1:0]         unused_redirect_lo;

    assign unused_redirect_lo = redirect_pc[1:0];

    // No new request while the buffer has no room or a redirect is in flight.
    assign imem_req  = (state_q == ST_REQ) && !fifo_full && !redirect;
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;
    assign fifo_push = (state_q == ST_WAIT) && imem_rvalid;
    assign fifo_pop  = if_ready && !fifo_empty;
    assign if_valid  = (fifo_count != 2'd0);
    assign if_pc     = fifo_head[XLEN+INST_W-1:INST_W];
    assign if_inst   = fifo_head[INST_W-1:0];
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (grant) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                end
            end
            ST_WAIT: if (imem_rvalid) state_d = ST_REQ;
            ST_DROP: if (imem_rvalid) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
            // A response still owed by memory must be swallowed in DROP. If it
            // arrives in this very cycle it is discarded by the flush, nothing
            // remains outstanding, and fetch can resume straight away.
            if (((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rvalid) ||
                (state_q == ST_REQ && grant)) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= align_pc(RESET_PC);
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .W     (XLEN + INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({req_pc_q, imem_rdata}),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         if_valid;
    logic [31:0]  if_inst;
    logic [31:0]  if_pc;
    logic         if_ready;
    fetch_state_e dbg_state;

    int n_vec;
    int n_err;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         gnt;
        logic         rvalid;
        logic [31:0]  rdata;
        logic         ready;
        logic         exp_req;
        logic [31:0]  exp_addr;
        logic         exp_valid;
        logic [31:0]  exp_pc;
        logic [31:0]  exp_inst;
        fetch_state_e exp_state;
    } vec_t;

    vec_t vecs [8];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input fetch_state_e act, input fetch_state_e exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %s expected %s", name, act.name(), exp.name());
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        redirect    = redir;
        redirect_pc = rpc;
        if_ready    = rdy;
        #1;
    endtask

    task automatic chk_out(input string name, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc, input logic [31:0] inst);
        chk_bit({name, ".req"}, imem_req, req);
        if (req) chk_word({name, ".addr"}, imem_addr, addr);
        chk_bit({name, ".valid"}, if_valid, vld);
        if (vld) begin
            chk_word({name, ".if_pc"}, if_pc, pc);
            chk_word({name, ".if_inst"}, if_inst, inst);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b0;

        // Sequential stream: grant always, response one cycle after grant.
        vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         ST_IDLE};
        vecs[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,         ST_REQ};
        vecs[2] = '{1'b1, 1'b1, 32'hA000_0013, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         ST_WAIT};
        vecs[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'hA000_0013, ST_REQ};
        vecs[4] = '{1'b1, 1'b1, 32'hA040_0013, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         ST_WAIT};
        vecs[5] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8, 1'b1, 32'h4, 32'hA040_0013, ST_REQ};
        vecs[6] = '{1'b1, 1'b1, 32'hA080_0013, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         ST_WAIT};
        vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'hA080_0013, ST_REQ};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk_state("rst.state", dbg_state, ST_IDLE);
        chk_bit("rst.req", imem_req, 1'b0);
        chk_bit("rst.valid", if_valid, 1'b0);
        chk_word("rst.if_inst", if_inst, 32'h0);
        chk_word("rst.if_pc", if_pc, 32'h0);

        // Table: release reset together with the first row.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            redirect    = 1'b0;
            if_ready    = vecs[i].ready;
            #1;
            chk_state($sformatf("vec%0d.state", i), dbg_state, vecs[i].exp_state);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                    vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_inst);
        end

        // Back-pressure: two words buffered, requests stop, head holds, drain in order.
        drive(1, 0, 32'h0, 0, 32'h0, 0);          chk_out("bp.req0", 1, 32'hC, 0, 0, 0);
        drive(0, 1, 32'hD00C_0013, 0, 32'h0, 0);  chk_out("bp.rsp0", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h0, 0, 32'h0, 0);          chk_out("bp.req1", 1, 32'h10, 1, 32'hC, 32'hD00C_0013);
        drive(0, 1, 32'hD010_0013, 0, 32'h0, 0);  chk_out("bp.rsp1", 0, 0, 1, 32'hC, 32'hD00C_0013);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h0, 0, 32'h0, 0);
            chk_out($sformatf("bp.hold%0d", i), 0, 0, 1, 32'hC, 32'hD00C_0013);
        end
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_out("bp.drain0", 0, 0, 1, 32'hC, 32'hD00C_0013);
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_out("bp.drain1", 1, 32'h14, 1, 32'h10, 32'hD010_0013);
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_out("bp.empty", 1, 32'h14, 0, 0, 0);

        // Redirect while waiting: stale response dropped, fetch from aligned target.
        drive(1, 0, 32'h0, 0, 32'h0, 1);          chk_out("rw.req", 1, 32'h14, 0, 0, 0);
        drive(0, 0, 32'h0, 1, 32'h0000_0103, 1);
        chk_state("rw.state_wait", dbg_state, ST_WAIT);
        chk_bit("rw.req_redir", imem_req, 1'b0);
        drive(0, 1, 32'hDEAD_0013, 0, 32'h0, 1);
        chk_state("rw.state_drop", dbg_state, ST_DROP);
        chk_out("rw.drop", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h0, 0, 32'h0, 1);          chk_out("rw.newreq", 1, 32'h100, 0, 0, 0);
        drive(0, 1, 32'hE100_0013, 0, 32'h0, 1);  chk_out("rw.rsp", 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_out("rw.deliver", 1, 32'h104, 1, 32'h100, 32'hE100_0013);

        // Redirect coinciding with a transfer and a push: everything flushed.
        drive(1, 0, 32'h0, 0, 32'h0, 0);          chk_out("rf.req0", 1, 32'h104, 0, 0, 0);
        drive(0, 1, 32'hD104_0013, 0, 32'h0, 0);  chk_out("rf.rsp0", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h0, 0, 32'h0, 0);          chk_out("rf.req1", 1, 32'h108, 1, 32'h104, 32'hD104_0013);
        drive(0, 1, 32'hD108_0013, 1, 32'h300, 1);
        chk_bit("rf.req_redir", imem_req, 1'b0);
        chk_bit("rf.valid_redir", if_valid, 1'b1);
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_out("rf.flushed", 1, 32'h300, 0, 0, 0);
        drive(1, 0, 32'h0, 0, 32'h0, 1);          chk_out("rf.req2", 1, 32'h300, 0, 0, 0);
        drive(0, 1, 32'hD300_0013, 0, 32'h0, 1);  chk_out("rf.rsp2", 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_out("rf.deliver", 1, 32'h304, 1, 32'h300, 32'hD300_0013);

        // Redirect while already dropping: stays in DROP, latest target wins.
        drive(1, 0, 32'h0, 0, 32'h0, 1);          chk_out("rd.req", 1, 32'h304, 0, 0, 0);
        drive(0, 0, 32'h0, 1, 32'h400, 1);        chk_state("rd.wait", dbg_state, ST_WAIT);
        drive(0, 0, 32'h0, 1, 32'h502, 1);        chk_state("rd.drop0", dbg_state, ST_DROP);
        chk_bit("rd.req_drop0", imem_req, 1'b0);
        drive(0, 1, 32'hBAD0_0013, 0, 32'h0, 1);  chk_state("rd.drop1", dbg_state, ST_DROP);
        chk_out("rd.drop1o", 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_state("rd.back", dbg_state, ST_REQ);
        chk_out("rd.newreq", 1, 32'h500, 0, 0, 0);

        // Address wrap at the top of memory.
        drive(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 1);  chk_bit("wr.req_redir", imem_req, 1'b0);
        drive(1, 0, 32'h0, 0, 32'h0, 1);          chk_out("wr.req_top", 1, 32'hFFFF_FFFC, 0, 0, 0);
        drive(0, 1, 32'hDFFC_0013, 0, 32'h0, 1);  chk_out("wr.rsp", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h0, 0, 32'h0, 1);          chk_out("wr.req_zero", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'hDFFC_0013);

        // Reset during WAIT, then a late response: ignored, restart at RESET_PC.
        @(negedge clk);
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk_state("mr.state", dbg_state, ST_IDLE);
        chk_bit("mr.req", imem_req, 1'b0);
        chk_bit("mr.valid", if_valid, 1'b0);
        chk_word("mr.if_pc", if_pc, 32'h0);
        chk_word("mr.if_inst", if_inst, 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1A7E_0013;
        #1;
        chk_state("mr.idle", dbg_state, ST_IDLE);
        chk_out("mr.late0", 0, 0, 0, 0, 0);
        drive(0, 1, 32'h1A7E_0013, 0, 32'h0, 1);
        chk_state("mr.req_state", dbg_state, ST_REQ);
        chk_out("mr.late1", 1, 32'h0, 0, 0, 0);
        drive(1, 0, 32'h0, 0, 32'h0, 1);          chk_out("mr.req0", 1, 32'h0, 0, 0, 0);
        drive(0, 1, 32'hC000_0013, 0, 32'h0, 1);  chk_out("mr.rsp0", 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);          chk_out("mr.deliver", 1, 32'h4, 1, 32'h0, 32'hC000_0013);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, number of instruction buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 imem_req  output  1  instruction memory request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 2'b00.
REQ-007 imem_gnt  input  1  memory accepts the request in the same cycle as imem_req.
REQ-008 imem_rvalid  input  1  read data valid; arrives one or more cycles after the grant, in order.
REQ-009 imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-010 redirect  input  1  taken branch or jal from decode/execute.
REQ-011 redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced to 0).
REQ-012 if_valid  output  1  if_inst and if_pc hold a valid instruction for decode.
REQ-013 if_inst  output  32  instruction word; its bits [6:0] are the opcode consumed by the control decoder.
REQ-014 if_pc  output  32  address of if_inst.
REQ-015 if_ready  input  1  decode accepts the instruction; a transfer occurs when if_valid=1 and if_ready=1.

Function
REQ-016 At most one memory request is outstanding at a time.
REQ-017 FSM states are IDLE, REQ, WAIT and DROP.
- IDLE: held one cycle after reset release, then goes to REQ.
- REQ: imem_req=1 when the FIFO count is below 2; on grant, go to WAIT and advance pc by 4.
- WAIT: on imem_rvalid, push {pc_of_req, imem_rdata} into the FIFO and return to REQ.
- DROP: on imem_rvalid, discard the data and return to REQ.
REQ-018 imem_addr equals the pc register whenever imem_req=1; pc arithmetic is modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
REQ-019 The FIFO is 2 entries of {pc, inst}, registered; if_valid = (count != 0); if_inst and if_pc come from the head entry.
REQ-020 A push and a pop in the same cycle leave the count unchanged; a push is never issued when the FIFO is full, which REQ-017 guarantees.
REQ-021 A response pushed in cycle N is visible on if_valid in cycle N+1 (minimum latency from grant to if_valid is 2 cycles).
REQ-022 Redirect has priority over every other event in its cycle:
- flush the FIFO (count becomes 0; any concurrent pop or push is discarded);
- load pc with {redirect_pc[31:2], 2'b00};
- if the state is WAIT, or REQ with a grant in the same cycle, go to DROP; otherwise go to REQ.
REQ-023 A redirect while in DROP keeps the state DROP and updates pc; the stale response is still discarded.
REQ-024 imem_req is 0 in IDLE, WAIT and DROP, and 0 in the cycle redirect=1.
REQ-025 if_valid=1 with if_ready=0 holds if_inst and if_pc stable until the transfer or a redirect.

Reset
REQ-026 While rst_n=0:
- state=IDLE, pc=RESET_PC, FIFO count=0;
- imem_req=0, if_valid=0, if_inst=0, if_pc=0.
REQ-027 Asserting reset mid-transaction abandons it; a response arriving after reset release, before the first grant, is ignored.

Structure
REQ-028 State encodings, RESET_PC and the instruction-width constant belong in the shared macro/package file that already holds the opcode definitions.
REQ-029 The 2-entry buffer is one sub-module, fetch_fifo, with push/pop/flush ports and count/empty/full outputs; the FSM and pc stay in fetch_unit.

Verification
REQ-030 Reset release, gnt always 1, rvalid 1 cycle after grant, if_ready=1 -> addresses 0, 4, 8 issued; if_pc sequence 0, 4, 8 with matching words; first if_valid at cycle 3 after reset release.
REQ-031 if_ready=0 for 10 cycles -> exactly 2 words buffered; imem_req drops to 0; if_inst stable; releasing if_ready drains both entries in order.
REQ-032 Redirect to 32'h0000_0103 while in WAIT -> the next address issued is 32'h0000_0100; the old response is dropped; no instruction with the old pc reaches if_valid.
REQ-033 Redirect in the same cycle as if_valid&if_ready and a push -> FIFO empty next cycle; first delivered if_pc equals the redirect target.
REQ-034 pc=32'hFFFF_FFFC fetched -> the next request address is 32'h0000_0000.
REQ-035 rst_n pulsed low during WAIT, then a late rvalid -> if_valid stays 0; fetch restarts at RESET_PC.
